// File: rtl/ip_tx_header.sv
// rtl/ip_tx_header.sv - IPv4 transmit header builder: checksum, byte-wise RAM write, Ethernet handoff
module ip_tx_header #(
    parameter logic [31:0] SOURCE_IP = 32'hC0A8010A,
    parameter logic [7:0]  TTL       = 8'h40,
    parameter logic [7:0]  HDR_BASE  = 8'h0E
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sendDatagram,
    input  logic [15:0] sendDatagramSize,
    input  logic [31:0] destinationIP,
    input  logic [7:0]  protocolIn,
    input  logic [2:0]  addressOffset,
    input  logic        complete,
    output logic        wrRAM,
    output logic [7:0]  wrAddr,
    output logic [7:0]  wrData,
    output logic        busy,
    output logic        sizeError,
    output logic        frameSend,
    output logic [15:0] frameSize,
    output logic [2:0]  frameOffset,
    input  logic        frameDone
);

    typedef enum logic [2:0] {IDLE, SUM, FOLD, WRITE, SEND, WAITTX} state_t;

    state_t      state;
    logic [31:0] destLatched;
    logic [7:0]  protoLatched;
    logic [15:0] idCounter;
    logic [15:0] curId;
    logic [16:0] acc;
    logic [15:0] ck;
    logic [3:0]  sumIdx;
    logic [4:0]  byteIdx;
    logic [4:0]  nextByte;
    logic [15:0] foldSum;

    assign nextByte = byteIdx + 5'd1;
    assign foldSum  = acc[15:0] + {15'd0, acc[16]};

    // frameSize doubles as the latched total length field
    function automatic logic [15:0] headerWord(input logic [3:0] idx, input logic [15:0] ckWord);
        case (idx)
            4'd0:    headerWord = 16'h4500;
            4'd1:    headerWord = frameSize;
            4'd2:    headerWord = curId;
            4'd3:    headerWord = 16'h4000;
            4'd4:    headerWord = {TTL, protoLatched};
            4'd5:    headerWord = ckWord;
            4'd6:    headerWord = SOURCE_IP[31:16];
            4'd7:    headerWord = SOURCE_IP[15:0];
            4'd8:    headerWord = destLatched[31:16];
            4'd9:    headerWord = destLatched[15:0];
            default: headerWord = 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] headerByte(input logic [4:0] idx);
        logic [15:0] w;
        w = headerWord(idx[4:1], ck);
        headerByte = idx[0] ? w[7:0] : w[15:8];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            destLatched  <= '0;
            protoLatched <= '0;
            idCounter    <= '0;
            curId        <= '0;
            acc          <= '0;
            ck           <= '0;
            sumIdx       <= '0;
            byteIdx      <= '0;
            wrRAM        <= 1'b0;
            wrAddr       <= '0;
            wrData       <= '0;
            busy         <= 1'b0;
            sizeError    <= 1'b0;
            frameSend    <= 1'b0;
            frameSize    <= '0;
            frameOffset  <= '0;
        end else begin
            sizeError <= 1'b0;
            frameSend <= 1'b0;
            case (state)
                IDLE: begin
                    if (sendDatagram) begin
                        if (sendDatagramSize > 16'd65515) begin
                            sizeError <= 1'b1;
                        end else begin
                            frameSize    <= sendDatagramSize + 16'd20;
                            destLatched  <= destinationIP;
                            protoLatched <= protocolIn;
                            frameOffset  <= addressOffset;
                            curId        <= idCounter;
                            acc          <= '0;
                            sumIdx       <= '0;
                            busy         <= 1'b1;
                            state        <= SUM;
                        end
                    end
                end
                SUM: begin
                    // end-around carry deferred one word; FOLD absorbs the last one
                    acc <= {1'b0, acc[15:0]} + {16'd0, acc[16]}
                         + {1'b0, headerWord(sumIdx, 16'h0000)};
                    sumIdx <= sumIdx + 4'd1;
                    if (sumIdx == 4'd9) state <= FOLD;
                end
                FOLD: begin
                    ck      <= ~foldSum;
                    byteIdx <= '0;
                    wrRAM   <= 1'b1;
                    wrAddr  <= HDR_BASE;
                    wrData  <= 8'h45;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (complete) begin
                        if (byteIdx == 5'd19) begin
                            wrRAM     <= 1'b0;
                            frameSend <= 1'b1;
                            state     <= SEND;
                        end else begin
                            byteIdx <= nextByte;
                            wrAddr  <= HDR_BASE + {3'd0, nextByte};
                            wrData  <= headerByte(nextByte);
                        end
                    end
                end
                SEND: begin
                    idCounter <= idCounter + 16'd1;
                    state     <= WAITTX;
                end
                WAITTX: begin
                    if (frameDone) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_tx_header.sv
// tb/tb_ip_tx_header.sv - randomized self-checking bench for ip_tx_header against a header model
module tb_ip_tx_header;

    localparam logic [31:0] SRC = 32'hC0A8010A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sendDatagram;
    logic [15:0] sendDatagramSize;
    logic [31:0] destinationIP;
    logic [7:0]  protocolIn;
    logic [2:0]  addressOffset;
    logic        complete;
    logic        wrRAM;
    logic [7:0]  wrAddr;
    logic [7:0]  wrData;
    logic        busy;
    logic        sizeError;
    logic        frameSend;
    logic [15:0] frameSize;
    logic [2:0]  frameOffset;
    logic        frameDone;

    ip_tx_header dut (
        .clk(clk), .reset_n(reset_n), .sendDatagram(sendDatagram),
        .sendDatagramSize(sendDatagramSize), .destinationIP(destinationIP),
        .protocolIn(protocolIn), .addressOffset(addressOffset), .complete(complete),
        .wrRAM(wrRAM), .wrAddr(wrAddr), .wrData(wrData), .busy(busy),
        .sizeError(sizeError), .frameSend(frameSend), .frameSize(frameSize),
        .frameOffset(frameOffset), .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] expQ[$];
    int expId = 0;
    int frameSendCnt = 0;
    int expFrameSendCnt = 0;
    int hold13 = 0;
    int capIdx = 0;
    logic [7:0] lastBytes[20];
    logic [15:0] expSize;
    logic [2:0]  expOff;
    int compMode = 0;
    int stallCnt = 0;
    logic prevWr = 1'b0, prevComp = 1'b0, prevFs = 1'b0;
    logic [7:0] prevAddr = '0, prevData = '0;
    logic [7:0] test1Bytes[20] = '{8'h45, 8'h00, 8'h00, 8'h54, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h01,
                                   8'hB7, 8'h4D, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h01};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not as required", name);
    endtask

    always @(posedge clk) begin
        #1;
        if (compMode == 1) complete = 1'($urandom_range(0, 1));
        else if (compMode == 2 && wrRAM && wrAddr == 8'h13 && stallCnt < 3) begin
            complete = 1'b0;
            stallCnt++;
        end else complete = 1'b1;
    end

    // Monitor: every accepted byte write is compared with the model's queue.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset_n) begin
            prevWr = 1'b0;
            prevFs = 1'b0;
        end else begin
            if (prevWr && !prevComp) begin
                check("holdWr", wrRAM, 1);
                check("holdAddr", wrAddr, prevAddr);
                check("holdData", wrData, prevData);
            end
            if (wrRAM && wrAddr == 8'h13) hold13++;
            if (wrRAM && complete) begin
                if (expQ.size() == 0) fail("unexpectedWrite");
                else begin
                    e = expQ.pop_front();
                    check("wrAddr", wrAddr, e[15:8]);
                    check("wrData", wrData, e[7:0]);
                    if (capIdx < 20) lastBytes[capIdx] = wrData;
                    capIdx++;
                end
            end
            if (frameSend) begin
                frameSendCnt++;
                check("sendQueueEmpty", expQ.size(), 0);
                check("sendNoWr", wrRAM, 0);
            end
            if (prevFs) check("frameSendPulse", frameSend, 0);
            prevWr = wrRAM;
            prevComp = complete;
            prevAddr = wrAddr;
            prevData = wrData;
            prevFs = frameSend;
        end
    end

    task automatic startReq(input logic [15:0] size, input logic [31:0] dst,
                            input logic [7:0] proto, input logic [2:0] off);
        logic [15:0] w[10];
        logic [15:0] totLen;
        int s;
        totLen = size + 16'd20;
        w = '{16'h4500, totLen, expId[15:0], 16'h4000, {8'h40, proto}, 16'h0000,
              SRC[31:16], SRC[15:0], dst[31:16], dst[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s += int'(w[i]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        w[5] = ~s[15:0];
        for (int i = 0; i < 20; i++)
            expQ.push_back({8'h0E + 8'(i), (i % 2 == 1) ? w[i/2][7:0] : w[i/2][15:8]});
        capIdx = 0;
        expSize = totLen;
        expOff = off;
        @(posedge clk); #1;
        sendDatagramSize = size;
        destinationIP = dst;
        protocolIn = proto;
        addressOffset = off;
        sendDatagram = 1'b1;
    endtask

    task automatic finishReq(input int expLat, input bit inject);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 400) begin
            @(negedge clk);
            if (n == 1) check("busyAccepted", busy, 1);
            if (frameSend) done = 1'b1;
            else begin
                @(posedge clk); #1;
                sendDatagram = 1'b0;
                frameDone = 1'b0;
                if (inject && n == 19) begin
                    sendDatagramSize = 16'd7;
                    sendDatagram = 1'b1;
                end
                if (inject && n == 21) frameDone = 1'b1;
                n++;
            end
        end
        if (!done) fail("frameSendTimeout");
        else if (expLat >= 0) check("latency", n, expLat);
        check("frameSize", frameSize, expSize);
        check("frameOffset", frameOffset, expOff);
        expId = (expId + 1) & 16'hFFFF;
        expFrameSendCnt++;
        @(posedge clk); #1;
        sendDatagram = inject;
        @(posedge clk); #1;
        sendDatagram = 1'b0;
        @(negedge clk);
        check("busyWaitTx", busy, 1);
        @(posedge clk); #1;
        frameDone = 1'b1;
        @(posedge clk); #1;
        frameDone = 1'b0;
        @(negedge clk);
        check("busyDone", busy, 0);
        check("frameSizeHold", frameSize, expSize);
        check("frameSendCount", frameSendCnt, expFrameSendCnt);
    endtask

    task automatic sizeReject(input logic [15:0] size);
        @(posedge clk); #1;
        sendDatagramSize = size;
        sendDatagram = 1'b1;
        @(posedge clk); #1;
        sendDatagram = 1'b0;
        @(negedge clk);
        check("sizeErrorPulse", sizeError, 1);
        check("sizeErrorBusy", busy, 0);
        @(negedge clk);
        check("sizeErrorEnd", sizeError, 0);
        check("sizeErrorIdle", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        sendDatagram = 1'b0;
        sendDatagramSize = '0;
        destinationIP = '0;
        protocolIn = '0;
        addressOffset = '0;
        frameDone = 1'b0;
        complete = 1'b1;
        repeat (3) @(negedge clk);
        check("rstOutputs", {wrRAM, wrAddr, wrData, busy, sizeError, frameSend, frameSize, frameOffset}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Test 1 and 2: known header, then id increments
        startReq(16'd64, 32'hC0A80101, 8'h01, 3'd5);
        finishReq(32, 1'b0);
        for (int i = 0; i < 20; i++) check($sformatf("t1byte%0d", i), lastBytes[i], test1Bytes[i]);
        check("t1frameSize", frameSize, 16'h0054);
        startReq(16'd64, 32'hC0A80101, 8'h01, 3'd2);
        finishReq(32, 1'b0);
        check("t2ckHi", lastBytes[10], 8'hB7);
        check("t2ckLo", lastBytes[11], 8'h4C);
        check("t2idLo", lastBytes[5], 8'h01);

        // Test 3: stalled completion on byte 5
        compMode = 2;
        stallCnt = 0;
        hold13 = 0;
        startReq(16'd64, 32'hC0A80101, 8'h11, 3'd1);
        finishReq(35, 1'b0);
        check("t3hold13", hold13, 4);
        compMode = 0;

        // Test 4: size boundary
        sizeReject(16'd65516);
        startReq(16'd65515, 32'h0A000001, 8'h11, 3'd7);
        finishReq(32, 1'b0);
        check("t4totLen", {lastBytes[2], lastBytes[3]}, 16'hFFFF);

        // Test 5: requests and frameDone while busy are ignored
        startReq(16'd100, 32'h08080808, 8'h11, 3'd3);
        finishReq(32, 1'b1);

        // Randomized requests with random completion back-pressure
        compMode = 1;
        for (int k = 0; k < 8; k++) begin
            logic [15:0] sz;
            sz = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65500, 65535))
                                             : 16'($urandom_range(0, 1500));
            if (sz > 16'd65515) sizeReject(sz);
            else begin
                startReq(sz, $urandom, 8'($urandom), 3'($urandom));
                finishReq(-1, 1'b0);
            end
        end
        compMode = 0;

        // Test 6: reset during byte 7 abandons the frame and clears the id
        begin
            int n;
            n = 0;
            startReq(16'd64, 32'hC0A80101, 8'h01, 3'd4);
            while (n < 100 && !(wrRAM && wrAddr == 8'h15)) begin
                @(negedge clk);
                if (!(wrRAM && wrAddr == 8'h15)) begin
                    @(posedge clk); #1;
                    sendDatagram = 1'b0;
                    n++;
                end
            end
            if (n >= 100) fail("t6reachByte7");
            #2;
            reset_n = 1'b0;
            sendDatagram = 1'b0;
            #1;
            check("t6rstOutputs", {wrRAM, wrAddr, wrData, busy, sizeError, frameSend, frameSize, frameOffset}, 0);
            expQ.delete();
            expId = 0;
            @(posedge clk); @(posedge clk); #1;
            reset_n = 1'b1;
            startReq(16'd64, 32'hC0A80101, 8'h01, 3'd0);
            finishReq(32, 1'b0);
            check("t6ckHi", lastBytes[10], 8'hB7);
            check("t6ckLo", lastBytes[11], 8'h4D);
        end

        repeat (3) @(negedge clk);
        check("finalFrameSendCount", frameSendCnt, expFrameSendCnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
